reg_pipe: RTL and testbench



---
 rtl/reg_pipe_pkg.sv | 13 +
 rtl/reg_pipe_stage.sv | 82 ++++++++
 rtl/reg_pipe.sv | 116 +++++++++++
 tb/tb_reg_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg
//   Shared definitions for the reg_pipe elastic pipeline.
//   - RST_FILL    : fill bit for the default stage data reset value
//   - count_width : width of the occupancy counter, clog2(depth + 1)
package reg_pipe_pkg;

    localparam logic RST_FILL = 1'b0;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage
//   One pipeline stage: a valid flag plus a payload register with a
//   load enable. The payload is only written when the incoming valid is
//   set, so bubbles passing through leave the stored data untouched.
//   Optional macro REG_PIPE_DATA_RST_EN: the payload register is also
//   loaded with RST_VAL on rst and flush_i. Without it the payload
//   register has no reset.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   flush_i      synchronous clear of the valid flag
//   load_i       stage accepts the upstream valid/data this cycle
//   up_valid_i   upstream valid
//   up_data_i    upstream payload
//   valid_o      stage holds valid data
//   data_o       stage payload
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int unsigned        DWIDTH  = 32,
    parameter logic [DWIDTH-1:0]  RST_VAL = {DWIDTH{RST_FILL}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              up_valid_i,
    input  logic [DWIDTH-1:0] up_data_i,
    output logic              valid_o,
    output logic [DWIDTH-1:0] data_o
);

    logic              v_d, v_q;
    logic [DWIDTH-1:0] d_d, d_q;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush_i) begin
            v_d = 1'b0;
        end else if (load_i) begin
            v_d = up_valid_i;
            if (up_valid_i) begin
                d_d = up_data_i;
            end
        end
`ifdef REG_PIPE_DATA_RST_EN
        if (flush_i) begin
            d_d = RST_VAL;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_d;
        end
    end

`ifdef REG_PIPE_DATA_RST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= RST_VAL;
        end else begin
            d_q <= d_d;
        end
    end
`else
    // Payload deliberately has no reset; RST_VAL only matters with the macro.
    logic [DWIDTH-1:0] unused_rst_val;
    assign unused_rst_val = RST_VAL;

    always_ff @(posedge clk) begin
        d_q <= d_d;
    end
`endif

    assign valid_o = v_q;
    assign data_o  = d_q;

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe
//   Elastic DEPTH-stage pipeline register with valid/ready handshake,
//   per-stage bubble collapsing, synchronous flush and a registered
//   occupancy count. The last stage drives the outputs directly.
//   Optional macro REG_PIPE_DATA_RST_EN: stage data registers load
//   RST_VAL on rst/flush_i; otherwise out_data_o is only meaningful
//   while out_valid_o is set.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   in_valid_i    upstream data valid
//   in_data_i     upstream payload
//   in_ready_o    pipeline accepts in_data_i this cycle
//   out_valid_o   final stage holds valid data
//   out_data_o    final-stage payload
//   out_ready_i   downstream accepts this cycle
//   flush_i       synchronous discard of all in-flight entries
//   count_o       number of valid stages (registered)
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int unsigned        DWIDTH  = 32,
    parameter int unsigned        DEPTH   = 2,
    parameter logic [DWIDTH-1:0]  RST_VAL = {DWIDTH{RST_FILL}}
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid_i,
    input  logic [DWIDTH-1:0]               in_data_i,
    output logic                            in_ready_o,
    output logic                            out_valid_o,
    output logic [DWIDTH-1:0]               out_data_o,
    input  logic                            out_ready_i,
    input  logic                            flush_i,
    output logic [count_width(DEPTH)-1:0]   count_o
);

    localparam int unsigned CW = count_width(DEPTH);

    logic [DEPTH-1:0]  v;
    logic [DWIDTH-1:0] d [DEPTH];
    logic [DEPTH:0]    rdy;

    // Ready ripples from the output back to the input; built in one
    // procedural loop so each bit sees the already-updated bit above it.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready_i;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rdy[DEPTH-1-i] = !v[DEPTH-1-i] || rdy[DEPTH-i];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            reg_pipe_stage #(
                .DWIDTH  (DWIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .flush_i    (flush_i),
                .load_i     (rdy[k]),
                .up_valid_i (in_valid_i),
                .up_data_i  (in_data_i),
                .valid_o    (v[k]),
                .data_o     (d[k])
            );
        end else begin : g_next
            reg_pipe_stage #(
                .DWIDTH  (DWIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .flush_i    (flush_i),
                .load_i     (rdy[k]),
                .up_valid_i (v[k-1]),
                .up_data_i  (d[k-1]),
                .valid_o    (v[k]),
                .data_o     (d[k])
            );
        end
    end

    assign in_ready_o  = rdy[0] && !flush_i;
    assign out_valid_o = v[DEPTH-1];
    assign out_data_o  = d[DEPTH-1];

    logic          in_xfer, out_xfer;
    logic [CW-1:0] count_d, count_q;

    assign in_xfer  = in_valid_i && in_ready_o;
    assign out_xfer = out_valid_o && out_ready_i;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_reg_pipe.sv
module tb_reg_pipe;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid_i = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic          in_ready_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_ready_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [CW-1:0] count_o;

    reg_pipe #(
        .DWIDTH (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .flush_i     (flush_i),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   t;
        bit            strm;
    } ent_t;

    ent_t          sb[$];
    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;
    int unsigned   mcyc = 0;
    bit            stream_flag = 1'b0;
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_od = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: the model is an ordered list of accepted items; occupancy,
    // readiness and output order follow from it directly.
    always @(negedge clk) begin
        ent_t e;
        mcyc++;
        if (rst) begin
            sb.delete();
        end else begin
            chk("count", 32'(count_o), sb.size());
            chk("in_ready", 32'(in_ready_o),
                32'(((sb.size() < DEPTH) || out_ready_i) && !flush_i));
            if (sb.size() == 0) chk("valid_when_empty", 32'(out_valid_o), 32'd0);
            if (sb.size() == DEPTH) chk("valid_when_full", 32'(out_valid_o), 32'd1);
            if (prev_hold) begin
                chk("hold_valid", 32'(out_valid_o), 32'd1);
                chk("hold_data", 32'(out_data_o), 32'(prev_od));
            end
            if (out_valid_o && out_ready_i) begin
                chk("pop_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("data", 32'(out_data_o), 32'(e.data));
                    chk("latency_min", 32'((mcyc - e.t) >= DEPTH), 32'd1);
                    if (e.strm) chk("latency_exact", mcyc - e.t, DEPTH);
                end
            end
            if (in_valid_i && in_ready_o) begin
                e.data = in_data_i;
                e.t    = mcyc;
                e.strm = stream_flag;
                sb.push_back(e);
            end
            if (flush_i) sb.delete();
        end
        prev_hold = !rst && !flush_i && out_valid_o && !out_ready_i;
        prev_od   = out_data_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] val, input bit strm);
        bit done;
        done        = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = val;
        stream_flag = strm;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = in_ready_o;
            step();
        end
        in_valid_i  = 1'b0;
        stream_flag = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: item %0h never accepted", val);
        end
    endtask

    task automatic drain();
        bit empty;
        empty       = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 30 && !empty; i++) begin
            step();
            @(negedge clk);
            empty = (sb.size() == 0);
        end
        step();
        n_cmp++;
        if (!empty) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d items still expected", sb.size());
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ready", 32'(in_ready_o), 32'd1);
        step();

        // Streaming: exact DEPTH-cycle latency
        out_ready_i = 1'b1;
        step();
        send(16'h0011, 1'b1);
        send(16'h0022, 1'b1);
        send(16'h0033, 1'b1);
        drain();

        // Backpressure: three accepted, fourth stalls
        out_ready_i = 1'b0;
        send(16'h0101, 1'b0);
        send(16'h0202, 1'b0);
        send(16'h0303, 1'b0);
        in_valid_i = 1'b1;
        in_data_i  = 16'h0404;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_ready", 32'(in_ready_o), 32'd0);
            chk("bp_count", 32'(count_o), 32'd3);
            chk("bp_data", 32'(out_data_o), 32'h0101);
            step();
        end
        out_ready_i = 1'b1;
        send(16'h0404, 1'b0);
        send(16'h0505, 1'b0);
        drain();

        // Bubble collapse
        out_ready_i = 1'b0;
        send(16'hA5A5, 1'b0);
        step();
        step();
        send(16'h5B5B, 1'b0);
        step();
        step();
        @(negedge clk);
        chk("bubble_count", 32'(count_o), 32'd2);
        chk("bubble_valid", 32'(out_valid_o), 32'd1);
        chk("bubble_data", 32'(out_data_o), 32'hA5A5);
        step();

        // Flush with an input offered
        in_valid_i = 1'b1;
        in_data_i  = 16'h0099;
        flush_i    = 1'b1;
        @(negedge clk);
        chk("flush_ready", 32'(in_ready_o), 32'd0);
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_valid", 32'(out_valid_o), 32'd0);
        step();

        // Full pipe, simultaneous in/out, then reset mid-stream
        send(16'h1001, 1'b0);
        send(16'h1002, 1'b0);
        send(16'h1003, 1'b0);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data_i = DW'($urandom);
            @(negedge clk);
            chk("sim_count", 32'(count_o), 32'd3);
            chk("sim_ready", 32'(in_ready_o), 32'd1);
            step();
        end
        rst = 1'b1;
        step();
        rst        = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("midrst_count", 32'(count_o), 32'd0);
        chk("midrst_valid", 32'(out_valid_o), 32'd0);
        step();

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 2500; i++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            in_data_i   = DW'($urandom);
            out_ready_i = (i < 1250) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 2) == 0);
            flush_i     = ($urandom_range(0, 39) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            step();
        end
        rst     = 1'b0;
        flush_i = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
